// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one valid/ready memory port between
// NUM_REQ agents. Each grant latches the winner's request, runs the memory
// handshake with a watchdog, then pulses completion back to the winner only.
module mem_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 16,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ-1:0]               req_wr_rd_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wr_data_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  output logic                             req_err_o,
  output logic [DATA_WIDTH-1:0]            req_rd_data_o,
  output logic                             mem_valid_o,
  output logic                             mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_wr_data_o,
  input  logic                             mem_ready_i,
  input  logic [DATA_WIDTH-1:0]            mem_rd_data_i,
  output logic [$clog2(NUM_REQ)-1:0]       grant_o,
  output logic                             busy_o,
  output logic [15:0]                      txn_count_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       sel;
  logic                   sel_found;
  logic [IDX_W:0]         cand;
  logic                   lat_wr_rd;
  logic [ADDR_WIDTH-1:0]  lat_addr;
  logic [DATA_WIDTH-1:0]  lat_wr_data;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   err;
  logic [7:0]             wdog;
  logic [7:0]             wdog_inc;
  logic                   wdog_expired;
  logic [15:0]            txn_count;
  logic [IDX_W-1:0]       grant_next;

  // Pick the first requesting agent at or after rr_ptr, wrapping around, so
  // the most recently served agent naturally ends up with lowest priority.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!sel_found && req_valid_i[cand[IDX_W-1:0]]) begin
        sel       = cand[IDX_W-1:0];
        sel_found = 1'b1;
      end
    end
  end

  assign wdog_inc     = wdog + 8'd1;
  assign wdog_expired = (wdog_inc == 8'(TIMEOUT_CYC));
  assign grant_next   = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);

  // State register; reset drops any in-flight access without a completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode; a ready in the same cycle as watchdog expiry completes normally.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (sel_found) state_n = BUSY;
      BUSY:    if (mem_ready_i || wdog_expired) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request latch, watchdog, captured read data, rotation pointer and counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr      <= '0;
      grant       <= '0;
      lat_wr_rd   <= 1'b0;
      lat_addr    <= '0;
      lat_wr_data <= '0;
      rd_data     <= '0;
      err         <= 1'b0;
      wdog        <= '0;
      txn_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant       <= sel;
            lat_wr_rd   <= req_wr_rd_i[sel];
            lat_addr    <= req_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
            lat_wr_data <= req_wr_data_i[sel*DATA_WIDTH +: DATA_WIDTH];
            wdog        <= '0;
          end
        end
        BUSY: begin
          if (mem_ready_i) begin
            if (!lat_wr_rd) begin
              rd_data <= mem_rd_data_i;
            end
            err <= 1'b0;
          end else begin
            wdog <= wdog_inc;
            if (wdog_expired) begin
              err <= 1'b1;
            end
          end
        end
        DONE: begin
          rr_ptr    <= grant_next;
          txn_count <= txn_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs depend only on state and registers, never on inputs directly.
  always_comb begin
    req_ready_o = '0;
    if (state == DONE) begin
      req_ready_o[grant] = 1'b1;
    end
    req_err_o   = (state == DONE) && err;
    mem_valid_o = (state == BUSY);
    busy_o      = (state != IDLE);
  end

  assign req_rd_data_o = rd_data;
  assign mem_wr_rd_o   = lat_wr_rd;
  assign mem_addr_o    = lat_addr;
  assign mem_wr_data_o = lat_wr_data;
  assign grant_o       = grant;
  assign txn_count_o   = txn_count;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A behavioural memory
// answers the handshake; a scoreboard queue holds the expected completions in
// grant order and is compared both at the memory port and at the agent side.
module tb_mem_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ADDR_WIDTH  = 6;
  localparam int DATA_WIDTH  = 16;
  localparam int TIMEOUT_CYC = 15;

  logic                          clk;
  logic                          rst;
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_wr_rd_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          req_err_o;
  logic [DATA_WIDTH-1:0]         req_rd_data_o;
  logic                          mem_valid_o;
  logic                          mem_wr_rd_o;
  logic [ADDR_WIDTH-1:0]         mem_addr_o;
  logic [DATA_WIDTH-1:0]         mem_wr_data_o;
  logic                          mem_ready_i;
  logic [DATA_WIDTH-1:0]         mem_rd_data_i;
  logic [1:0]                    grant_o;
  logic                          busy_o;
  logic [15:0]                   txn_count_o;

  mem_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_wr_rd_i   (req_wr_rd_i),
    .req_addr_i    (req_addr_i),
    .req_wr_data_i (req_wr_data_i),
    .req_ready_o   (req_ready_o),
    .req_err_o     (req_err_o),
    .req_rd_data_o (req_rd_data_o),
    .mem_valid_o   (mem_valid_o),
    .mem_wr_rd_o   (mem_wr_rd_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_ready_i   (mem_ready_i),
    .mem_rd_data_i (mem_rd_data_i),
    .grant_o       (grant_o),
    .busy_o        (busy_o),
    .txn_count_o   (txn_count_o)
  );

  // One expected completion, in the order the arbiter should grant.
  typedef struct {
    int          agent;
    logic        wr;
    logic [5:0]  addr;
    logic [15:0] data;
    logic        err;
    logic [15:0] rdata;
  } sb_item_t;

  // One single-agent vector: stimulus, memory behaviour and expected outputs.
  typedef struct {
    int          agent;
    logic        wr;
    logic [5:0]  addr;
    logic [15:0] data;
    int          wait_cyc;
    logic        stuck;
    int          exp_lat;
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  sb_item_t    sb[$];
  vec_t        vecs[8];
  logic [15:0] mem_store [64];
  int          checks;
  int          errors;
  int          wait_cfg;
  int          mcount;
  logic        stuck;
  logic        hold_valid;
  logic        pulse_seen;
  logic [15:0] exp_txn;
  logic [15:0] exp_last_rd;

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic setAgent(input int k, input logic wr, input logic [5:0] addr, input logic [15:0] data);
    req_wr_rd_i[k]                         = wr;
    req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] = addr;
    req_wr_data_i[k*DATA_WIDTH +: DATA_WIDTH] = data;
  endtask

  task automatic pushExp(input int k, input logic wr, input logic [5:0] addr, input logic [15:0] data,
                         input logic err, input logic [15:0] rdata);
    sb_item_t it;
    it.agent = k;
    it.wr    = wr;
    it.addr  = addr;
    it.data  = data;
    it.err   = err;
    it.rdata = rdata;
    sb.push_back(it);
  endtask

  // Advance one cycle, sample #1 after the edge, score completions and
  // play the memory for the coming cycle.
  task automatic tick();
    sb_item_t it;
    @(posedge clk);
    #1;
    pulse_seen = 1'b0;
    if (req_ready_o != '0) begin
      pulse_seen = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected_pulse: got mask 0x%0h, required none", req_ready_o);
      end else begin
        it = sb.pop_front();
        checkOutput("done_mask", 32'(req_ready_o), 32'(1 << it.agent));
        checkOutput("done_err", 32'(req_err_o), 32'(it.err));
        if (!it.wr && !it.err) begin
          checkOutput("done_rd_data", 32'(req_rd_data_o), 32'(it.rdata));
          exp_last_rd = it.rdata;
        end else begin
          checkOutput("done_rd_hold", 32'(req_rd_data_o), 32'(exp_last_rd));
        end
        checkOutput("done_txn_count", 32'(txn_count_o), 32'(exp_txn));
        exp_txn = exp_txn + 16'd1;
      end
      if (!hold_valid) req_valid_i = req_valid_i & ~req_ready_o;
      stuck = 1'b0;
    end
    if (mem_valid_o) begin
      mcount++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL mem_valid_unexpected: got 1, required 0");
      end else begin
        it = sb[0];
        checkOutput("mem_grant", 32'(grant_o), 32'(it.agent));
        checkOutput("mem_wr_rd", 32'(mem_wr_rd_o), 32'(it.wr));
        checkOutput("mem_addr", 32'(mem_addr_o), 32'(it.addr));
        if (it.wr) checkOutput("mem_wr_data", 32'(mem_wr_data_o), 32'(it.data));
      end
      if (!stuck && mcount > wait_cfg) begin
        mem_ready_i = 1'b1;
        if (mem_wr_rd_o) begin
          mem_store[mem_addr_o] = mem_wr_data_o;
          mem_rd_data_i = 16'($urandom);
        end else begin
          mem_rd_data_i = mem_store[mem_addr_o];
        end
      end else begin
        mem_ready_i   = 1'b0;
        mem_rd_data_i = 16'($urandom);
      end
    end else begin
      mcount        = 0;
      mem_ready_i   = 1'b0;
      mem_rd_data_i = 16'($urandom);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got %0d pending completions, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic checkZero(input string pfx);
    checkOutput({pfx, "_mem_valid"}, 32'(mem_valid_o), 32'd0);
    checkOutput({pfx, "_req_ready"}, 32'(req_ready_o), 32'd0);
    checkOutput({pfx, "_req_err"}, 32'(req_err_o), 32'd0);
    checkOutput({pfx, "_rd_data"}, 32'(req_rd_data_o), 32'd0);
    checkOutput({pfx, "_mem_wr_rd"}, 32'(mem_wr_rd_o), 32'd0);
    checkOutput({pfx, "_mem_addr"}, 32'(mem_addr_o), 32'd0);
    checkOutput({pfx, "_mem_wr_data"}, 32'(mem_wr_data_o), 32'd0);
    checkOutput({pfx, "_grant"}, 32'(grant_o), 32'd0);
    checkOutput({pfx, "_busy"}, 32'(busy_o), 32'd0);
    checkOutput({pfx, "_txn_count"}, 32'(txn_count_o), 32'd0);
  endtask

  // Drive one vector as a lone requester and measure the cycle of its pulse,
  // counting the cycle the request is first presented as cycle 1.
  task automatic applyStimulus(input vec_t v);
    int lat;
    wait_cfg = v.wait_cyc;
    stuck    = v.stuck;
    setAgent(v.agent, v.wr, v.addr, v.data);
    pushExp(v.agent, v.wr, v.addr, v.data, v.exp_err, v.exp_rdata);
    req_valid_i[v.agent] = 1'b1;
    lat = 1;
    pulse_seen = 1'b0;
    while (!pulse_seen && lat < 60) begin
      tick();
      lat++;
    end
    if (!pulse_seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL vec_no_pulse: got no pulse, required pulse at cycle %0d", v.exp_lat);
      sb.delete();
      req_valid_i = '0;
    end else begin
      checkOutput("vec_latency", 32'(lat), 32'(v.exp_lat));
    end
    tick();
  endtask

  task automatic resetDut();
    rst         = 1'b0;
    req_valid_i = '0;
    stuck       = 1'b0;
    wait_cfg    = 0;
    tick();
    tick();
    checkZero("reset");
    sb.delete();
    exp_txn     = 16'd0;
    exp_last_rd = 16'd0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    mcount        = 0;
    hold_valid    = 1'b0;
    pulse_seen    = 1'b0;
    stuck         = 1'b0;
    wait_cfg      = 0;
    exp_txn       = 16'd0;
    exp_last_rd   = 16'd0;
    rst           = 1'b0;
    req_valid_i   = '0;
    req_wr_rd_i   = '0;
    req_addr_i    = '0;
    req_wr_data_i = '0;
    mem_ready_i   = 1'b0;
    mem_rd_data_i = '0;
    for (int i = 0; i < 64; i++) mem_store[i] = 16'h0000;

    vecs[0] = '{2, 1'b1, 6'h05, 16'hA5A5, 0, 1'b0,  3, 1'b0, 16'h0000};
    vecs[1] = '{2, 1'b0, 6'h05, 16'h0000, 0, 1'b0,  3, 1'b0, 16'hA5A5};
    vecs[2] = '{1, 1'b1, 6'h3F, 16'h1234, 4, 1'b0,  7, 1'b0, 16'h0000};
    vecs[3] = '{1, 1'b0, 6'h3F, 16'h0000, 2, 1'b0,  5, 1'b0, 16'h1234};
    vecs[4] = '{0, 1'b1, 6'h00, 16'hFFFF, 0, 1'b0,  3, 1'b0, 16'h0000};
    vecs[5] = '{3, 1'b0, 6'h00, 16'h0000, 1, 1'b0,  4, 1'b0, 16'hFFFF};
    vecs[6] = '{0, 1'b1, 6'h10, 16'hBEEF, 0, 1'b1, 17, 1'b1, 16'h0000};
    vecs[7] = '{3, 1'b0, 6'h10, 16'h0000, 0, 1'b0,  3, 1'b0, 16'h0000};

    // Reset state, then all four agents requesting continuously from release.
    resetDut();
    setAgent(0, 1'b1, 6'h21, 16'h1111);
    setAgent(1, 1'b0, 6'h21, 16'h0000);
    setAgent(2, 1'b1, 6'h23, 16'h2222);
    setAgent(3, 1'b0, 6'h23, 16'h0000);
    for (int r = 0; r < 2; r++) begin
      pushExp(0, 1'b1, 6'h21, 16'h1111, 1'b0, 16'h0000);
      pushExp(1, 1'b0, 6'h21, 16'h0000, 1'b0, 16'h1111);
      pushExp(2, 1'b1, 6'h23, 16'h2222, 1'b0, 16'h0000);
      pushExp(3, 1'b0, 6'h23, 16'h0000, 1'b0, 16'h2222);
    end
    hold_valid  = 1'b1;
    rst         = 1'b1;
    req_valid_i = 4'b1111;
    repeat (24) tick();
    checkOutput("rr_txn_count", 32'(txn_count_o), 32'd8);
    checkOutput("rr_queue_empty", 32'(sb.size()), 32'd0);
    req_valid_i = '0;
    hold_valid  = 1'b0;
    tick();
    checkOutput("rr_idle_busy", 32'(busy_o), 32'd0);

    // Agent 3 served, then agents 0 and 3 together: agent 0 must win.
    setAgent(3, 1'b0, 6'h23, 16'h0000);
    pushExp(3, 1'b0, 6'h23, 16'h0000, 1'b0, 16'h2222);
    req_valid_i[3] = 1'b1;
    drain("prio_first");
    tick();
    setAgent(0, 1'b1, 6'h08, 16'h0808);
    setAgent(3, 1'b0, 6'h08, 16'h0000);
    pushExp(0, 1'b1, 6'h08, 16'h0808, 1'b0, 16'h0000);
    pushExp(3, 1'b0, 6'h08, 16'h0000, 1'b0, 16'h0808);
    req_valid_i = 4'b1001;
    drain("prio_pair");
    tick();

    // Single-agent vectors: latency, wait states, timeout, read-back.
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Timeout on agent 1 while agent 2 waits; agent 2 is served next.
    setAgent(1, 1'b1, 6'h30, 16'hCAFE);
    setAgent(2, 1'b0, 6'h30, 16'h0000);
    pushExp(1, 1'b1, 6'h30, 16'hCAFE, 1'b1, 16'h0000);
    pushExp(2, 1'b0, 6'h30, 16'h0000, 1'b0, 16'h0000);
    wait_cfg    = 0;
    stuck       = 1'b1;
    req_valid_i = 4'b0110;
    drain("timeout_pair");
    tick();

    // Reset during BUSY drops the access; afterwards agent 0 is granted first.
    setAgent(2, 1'b0, 6'h05, 16'h0000);
    pushExp(2, 1'b0, 6'h05, 16'h0000, 1'b0, 16'hA5A5);
    stuck          = 1'b1;
    req_valid_i[2] = 1'b1;
    repeat (3) tick();
    checkOutput("mid_busy", 32'(busy_o), 32'd1);
    checkOutput("mid_mem_valid", 32'(mem_valid_o), 32'd1);
    rst         = 1'b0;
    req_valid_i = '0;
    tick();
    checkZero("mid_reset");
    sb.delete();
    stuck       = 1'b0;
    exp_txn     = 16'd0;
    exp_last_rd = 16'd0;
    tick();
    checkOutput("mid_reset_no_pulse", 32'(req_ready_o), 32'd0);
    setAgent(0, 1'b1, 6'h11, 16'h5A5A);
    setAgent(2, 1'b0, 6'h11, 16'h0000);
    setAgent(3, 1'b0, 6'h05, 16'h0000);
    pushExp(0, 1'b1, 6'h11, 16'h5A5A, 1'b0, 16'h0000);
    pushExp(2, 1'b0, 6'h11, 16'h0000, 1'b0, 16'h5A5A);
    pushExp(3, 1'b0, 6'h05, 16'h0000, 1'b0, 16'hA5A5);
    rst         = 1'b1;
    req_valid_i = 4'b1101;
    drain("post_reset");
    tick();
    checkOutput("final_txn_count", 32'(txn_count_o), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single valid/ready port of `memory` between `NUM_REQ` independent agents.
- Each agent presents an addr/wr_rd/wr_data/valid request. The arbiter grants one agent at a time and latches its request. It drives the memory handshake, then returns completion (and read data) to the granted agent only.
- It sits between the agent-side drivers and the `memory` instance.
- A watchdog aborts any memory access that never sees `ready_o`.

## Interface
- `NUM_REQ`, 4, number of requesting agents (2..8)
- `ADDR_WIDTH`, 6, memory address width
- `DATA_WIDTH`, 16, memory data width
- `TIMEOUT_CYC`, 15, max cycles in BUSY waiting for `mem_ready_i` before abort (1..255)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-low reset (0 = reset, sampled on `clk` rising edge)
- `req_valid_i`  in  NUM_REQ  per-agent request valid
- `req_wr_rd_i`  in  NUM_REQ  per-agent 1 = write, 0 = read
- `req_addr_i`  in  NUM_REQ*ADDR_WIDTH  packed addresses, agent k at `[k*ADDR_WIDTH +: ADDR_WIDTH]`
- `req_wr_data_i`  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
- `req_ready_o`  out  NUM_REQ  one-cycle completion pulse to the granted agent
- `req_err_o`  out  1  qualifies `req_ready_o`: 1 = access aborted by timeout
- `req_rd_data_o`  out  DATA_WIDTH  read data; valid while `req_ready_o` is nonzero for a read
- `mem_valid_o`  out  1  to `memory.valid_i`
- `mem_wr_rd_o`  out  1  to `memory.wr_rd_i`
- `mem_addr_o`  out  ADDR_WIDTH  to `memory.addr_i`
- `mem_wr_data_o`  out  DATA_WIDTH  to `memory.wr_data_i`
- `mem_ready_i`  in  1  from `memory.ready_o`
- `mem_rd_data_i`  in  DATA_WIDTH  from `memory.rd_data_o`; valid in the cycle `mem_ready_i` = 1
- `grant_o`  out  $clog2(NUM_REQ)  index of the agent currently granted (debug/coverage)
- `busy_o`  out  1  1 in BUSY or DONE
- `txn_count_o`  out  16  completed transactions (including aborted ones), wraps 0xFFFF→0

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE:**
  - If any `req_valid_i` bit is set, select the first set bit scanning from `rr_ptr` upward, wrapping modulo NUM_REQ.
  - Latch that agent's wr_rd, addr and wr_data into internal registers, set `grant_o`, clear the watchdog, and go to BUSY.
  - If no bit is set, stay in IDLE.
- **BUSY:**
  - `mem_valid_o` = 1. `mem_wr_rd_o`, `mem_addr_o` and `mem_wr_data_o` come from the latched registers and stay stable until the handshake completes.
  - If `mem_ready_i` = 1: capture `mem_rd_data_i` (reads only; writes leave the read-data register unchanged), set err = 0, go to DONE.
  - Else increment the watchdog. When the watchdog reaches TIMEOUT_CYC, set err = 1 and go to DONE.
- **DONE:**
  - `req_ready_o[grant]` = 1 (all other bits 0), `req_err_o` = err, `req_rd_data_o` = captured data.
  - Set `rr_ptr` = (grant+1) mod NUM_REQ, increment `txn_count_o`, go to IDLE.
- **Agent contract:**
  - An agent holds valid and its fields stable until it sees its `req_ready_o` pulse.
  - The arbiter uses only the values latched in IDLE. An agent dropping valid during BUSY does not cancel the access; the access still completes and the pulse is still issued.
- **Fairness:** after a grant to agent k, agent k has lowest priority at the next arbitration. No agent waits more than NUM_REQ−1 grants.
- `mem_valid_o` is 0 in IDLE and DONE. The memory never sees back-to-back valid without an intervening low cycle.

## Timing
- **Reset:**
  - All outputs 0: `mem_valid_o`, `req_ready_o`, `req_err_o`, `req_rd_data_o`, `mem_*`, `grant_o`, `busy_o`, `txn_count_o`.
  - FSM = IDLE, `rr_ptr` = 0, watchdog = 0.
  - Reset asserted in any state forces IDLE on the next edge. The in-flight access is dropped with no `req_ready_o` pulse.
- **Latency:**
  - Valid sampled in IDLE at edge N.
  - `mem_valid_o` = 1 in cycle N+1.
  - If `mem_ready_i` = 1 in that same cycle, `req_ready_o` pulses in cycle N+2.
  - Best case is 3 cycles per transaction (IDLE→BUSY→DONE). Each extra memory wait cycle adds 1.
- **Timeout:** abort occurs after exactly TIMEOUT_CYC BUSY cycles with `mem_ready_i` = 0. DONE follows in the next cycle with `req_err_o` = 1.
- **Simultaneous events:** if `mem_ready_i` = 1 in the cycle the watchdog hits TIMEOUT_CYC, the completion wins (err = 0).
- All outputs are registered or decoded from state plus registers only. There is no combinational path from `req_*_i` or `mem_ready_i` to any output.

## Test plan
- **Single write/read:**
  - Agent 2 writes addr 0x05, data 0xA5A5 with memory ready immediately → `mem_valid_o` high 1 cycle, `req_ready_o` = 4'b0100 three cycles after request, `req_err_o` = 0.
  - Agent 2 then reads addr 0x05 → `req_rd_data_o` = 0xA5A5 with the pulse.
- **Round-robin:** all 4 agents hold valid continuously from reset → grant order 0,1,2,3,0,1…; `txn_count_o` = 8 after 24 cycles.
- **Priority rotation:** after agent 3 is served, agents 0 and 3 both request → agent 0 granted first.
- **Memory wait states:** `mem_ready_i` held low 4 cycles → `mem_addr_o`/`mem_wr_data_o` stable throughout, `req_ready_o` 7 cycles after request.
- **Timeout:** `mem_ready_i` stuck 0 → after 15 BUSY cycles, `req_ready_o` pulses with `req_err_o` = 1, then the next requester is granted.
- **Reset mid-access:** assert `rst` = 0 during BUSY → next cycle all outputs 0, no `req_ready_o` pulse; after release, agent 0 is granted first.
